lte_ul_srcx1_rx: RTL

LTE_UL_SRCX1_RX -- requirements
Module: lte_ul_srcx1_rx

---
 rtl/lte_ul_srcx1_pkg.sv | 7 +
 rtl/lte_ul_err_cnt.sv | 12 +
 rtl/lte_ul_srcx1_rx.sv | 80 ++++++++
 3 files changed

// File: rtl/lte_ul_srcx1_pkg.sv
// lte_ul_srcx1_pkg: shared constants and FSM encoding for the LTE UL 8-antenna deinterleaver
package lte_ul_srcx1_pkg;
  localparam int FRAME_LEN_DFLT = 4915200;
  localparam int NUM_ANT = 8;
  localparam int IQ_W = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, ALIGN = 2'd1, LOCK = 2'd2} state_t;
endpackage

// File: rtl/lte_ul_err_cnt.sv
// lte_ul_err_cnt: 16-bit saturating error counter, clear has priority over increment
module lte_ul_err_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] cnt
);
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (inc && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
endmodule

// File: rtl/lte_ul_srcx1_rx.sv
// lte_ul_srcx1_rx: frame/antenna alignment and 8-lane deinterleave of an IQ stream
// Optional window check enabled by defining LTE_UL_SRCX1_RX_WINCHK_EN.
module lte_ul_srcx1_rx #(
  parameter int FRAME_LEN = lte_ul_srcx1_pkg::FRAME_LEN_DFLT,
  parameter int NUM_ANT = lte_ul_srcx1_pkg::NUM_ANT
) (
  input  logic                                       clk,
  input  logic                                       asy_rst,
  input  logic [lte_ul_srcx1_pkg::IQ_W-1:0]          i_data_iq,
  input  logic                                       i_fram_hd,
  input  logic                                       i_ant8_sel,
  input  logic [31:0]                                i_data_start,
  input  logic [31:0]                                i_data_end,
  input  logic                                       i_err_clr,
  output logic [NUM_ANT*lte_ul_srcx1_pkg::IQ_W-1:0]  o_lane_iq,
  output logic                                       o_lane_vld,
  output logic                                       o_fram_hd,
  output logic                                       o_lock,
  output logic [1:0]                                 o_state,
  output logic [15:0]                                o_hd_err_cnt,
  output logic [15:0]                                o_sel_err_cnt,
  output logic [15:0]                                o_win_err_cnt
);
  import lte_ul_srcx1_pkg::*;
  localparam int IW = $clog2(FRAME_LEN);
  localparam int SW = $clog2(NUM_ANT);
  state_t st, st_nx;
  logic [IW-1:0] idx, cur_idx, idx_nx;
  logic [SW-1:0] slot, ws;
  logic [NUM_ANT-2:0][IQ_W-1:0] grp;
  logic hd_seen, grp_hd, active, hd_err, slip, miss, done;
  always_comb begin
    active = st != IDLE;
    cur_idx = i_fram_hd ? '0 : idx;
    idx_nx = (cur_idx == IW'(FRAME_LEN - 1)) ? '0 : cur_idx + 1'b1;
    hd_err = active && (i_fram_hd != (idx == '0));
    slip = st == LOCK && i_ant8_sel && slot != '0;
    miss = st == LOCK && !i_ant8_sel && slot == '0;
    st_nx = st == IDLE ? (i_fram_hd ? ALIGN : IDLE) :
            st == ALIGN ? (i_ant8_sel ? LOCK : ALIGN) : (slip ? ALIGN : LOCK);
    ws = st == LOCK ? slot : '0;
    done = st == LOCK && slot == SW'(NUM_ANT - 1) && !slip;
    grp_hd = (ws == '0 ? 1'b0 : hd_seen) | i_fram_hd;
  end
  // Lanes 0..6 collect in grp; the last-slot sample goes straight to the output.
  always_ff @(posedge clk)
    if (asy_rst) begin
      st <= IDLE;
      idx <= '0;
      slot <= '0;
      grp <= '0;
      hd_seen <= 1'b0;
      o_lane_iq <= '0;
      o_lane_vld <= 1'b0;
      o_fram_hd <= 1'b0;
    end else begin
      st <= st_nx;
      idx <= idx_nx;
      slot <= st == LOCK ? slot + 1'b1 : SW'(1);
      if (st_nx == LOCK && !done) grp[ws] <= i_data_iq;
      hd_seen <= grp_hd;
      o_lane_vld <= done;
      o_fram_hd <= done && grp_hd;
      if (done) o_lane_iq <= {i_data_iq, grp};
    end
  assign o_lock = st == LOCK;
  assign o_state = st;
  lte_ul_err_cnt u_hd (.clk(clk), .rst(asy_rst), .clr(i_err_clr), .inc(hd_err), .cnt(o_hd_err_cnt));
  lte_ul_err_cnt u_sel (.clk(clk), .rst(asy_rst), .clr(i_err_clr), .inc(slip || miss), .cnt(o_sel_err_cnt));
`ifdef LTE_UL_SRCX1_RX_WINCHK_EN
  logic win_err;
  assign win_err = active && i_data_iq != '0 &&
                   (32'(cur_idx) < i_data_start || 32'(cur_idx) > i_data_end);
  lte_ul_err_cnt u_win (.clk(clk), .rst(asy_rst), .clr(i_err_clr), .inc(win_err), .cnt(o_win_err_cnt));
`else
  logic unused_win;
  assign unused_win = ^{i_data_start, i_data_end};
  assign o_win_err_cnt = '0;
`endif
endmodule
